// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-requester round-robin arbiter for the mem data port, with a
//            read-tag pipe that steers returned words to their owner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int LATENCY = 1,
    parameter int AW      = 15,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_raddr,
    output logic          mem_wen,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic               r_last;
    logic [LATENCY-1:0] r_tag_vld;
    logic [LATENCY-1:0] r_tag_id;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_rd_push;

    // Under contention the requester that did not win last time goes first;
    // rst_n gates the grants so nothing reaches memory while in reset.
    assign w_gnt0 = rst_n & req0 & (~req1 | r_last);
    assign w_gnt1 = rst_n & req1 & (~req0 | ~r_last);

    assign gnt0 = w_gnt0;
    assign gnt1 = w_gnt1;

    always_comb begin
        mem_wen   = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        w_rd_push = 1'b0;
        if (w_gnt0) begin
            mem_wen   = we0;
            mem_raddr = addr0;
            mem_waddr = addr0;
            mem_wdata = wdata0;
            w_rd_push = ~we0;
        end else if (w_gnt1) begin
            mem_wen   = we1;
            mem_raddr = addr1;
            mem_waddr = addr1;
            mem_wdata = wdata1;
            w_rd_push = ~we1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_gnt0) begin
            r_last <= 1'b0;
        end else if (w_gnt1) begin
            r_last <= 1'b1;
        end
    end

    // Tag pipe is exactly as deep as the memory read latency, so the final
    // stage lines up with the word on mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_rd_push;
            r_tag_id[0]  <= w_gnt1;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    assign rvalid0 = r_tag_vld[LATENCY-1] & ~r_tag_id[LATENCY-1];
    assign rvalid1 = r_tag_vld[LATENCY-1] &  r_tag_id[LATENCY-1];
    assign rdata   = r_tag_vld[LATENCY-1] ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter for the single data read/write port of `mem`, the port the CPU uses for `ld`/`st`. Requester 0 is the CPU write-back stage. Requester 1 is the program loader / debug access port. The block grants at most one access per cycle and drives the memory's data-port signals. It tags each granted read so the returned word is steered to its owner after the fixed memory read latency.

## Interface
Parameters:
- `LATENCY`, 1: cycles from read address presented to `mem_rdata` valid (1..4).
- `AW`, 15: word-address width (byte address bits [15:1]).
- `DW`, 16: data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req0`, `req1`  in  1  access request from requester 0 / 1.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  AW  word address.
- `wdata0`, `wdata1`  in  DW  write data.
- `gnt0`, `gnt1`  out  1  access accepted this cycle.
- `rvalid0`, `rvalid1`  out  1  read data for this requester is on `rdata`.
- `rdata`  out  DW  returned read word; shared by both requesters.
- `mem_raddr`  out  AW  memory read address.
- `mem_wen`  out  1  memory write enable.
- `mem_waddr`  out  AW  memory write address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data.

## Operation
- State:
  - `last`: 1-bit id of the most recently granted requester. Reset value 1, so requester 0 wins the first tie.
  - Tag pipe: LATENCY stages of {valid, id}. Reset value all-invalid.
- Grant (combinational, same cycle as request):
  - Exactly one `req` high: that requester is granted.
  - Both `req` high: grant goes to the requester that is not `last`.
  - Neither high: no grant.
  - `gnt0 & gnt1` is never 1.
- Request handshake:
  - A requester holds `req`, `we`, `addr` and `wdata` stable until it sees its `gnt`.
  - A transfer occurs in the cycle where `req & gnt` are both 1.
  - The requester may drop `req` or present a new request in the following cycle.
  - A request never expires; it waits until granted.
- `last` update: on each edge with a grant, `last` takes the granted id. With no grant, `last` holds.
- Memory drive:
  - `mem_waddr`, `mem_wdata` and `mem_raddr` come from the granted requester's address and data.
  - `mem_wen = grant & we`.
  - With no grant: `mem_wen = 0` and `mem_raddr = 0`; `mem_waddr`/`mem_wdata` = 0.
- Read tagging:
  - A granted read pushes {1, id} into tag stage 0. A cycle with no read grant pushes {0, x}.
  - The tag pipe shifts every edge.
  - When the final stage is valid, `rvalid<id>` = 1 and `rdata = mem_rdata`. Otherwise both `rvalid` = 0 and `rdata = 0`.
- Writes produce no response. Ordering is single-port, so a read granted the cycle after a write to the same address returns the new data.
- All outputs while `rst_n` = 0: `gnt*` = 0, `rvalid*` = 0, `rdata` = 0, `mem_wen` = 0, address and data outputs = 0. Grants are suppressed during reset even with `req` high.

## Timing
- Grant latency: 0 cycles; `gnt` is combinational from `req` and `last`.
- Read data latency: `rvalid` is asserted exactly LATENCY cycles after the granted cycle, for one cycle.
- Throughput: one access per cycle in total. Under contention each requester receives every other cycle.
- Back-to-back reads from one requester produce back-to-back `rvalid` pulses.
- Reset asserted mid-operation:
  - The tag pipe clears immediately and in-flight reads are dropped; no `rvalid` is produced for them.
  - `last` returns to 1.
  - The first cycle after `rst_n` rises behaves as post-reset.
- Both requesters holding a request continuously: grants alternate 0,1,0,1 with no gaps.

## Test plan
- Reset: `rst_n` = 0 with `req0` = `req1` = 1 -> all outputs 0. Release; first cycle both request -> `gnt0` = 1, `gnt1` = 0.
- Single read: LATENCY = 1, `req0` read at 0x0010, memory word 0xBEEF -> `gnt0` same cycle; next cycle `rvalid0` = 1, `rdata` = 0xBEEF, `rvalid1` = 0.
- Contention: both requesters reading continuously for 6 cycles -> grants 0,1,0,1,0,1. `rvalid` ids follow the same sequence, delayed LATENCY cycles.
- Write then read: `req1` writes 0x1234 to 0x0040; the next cycle `req0` reads 0x0040 -> `mem_wen` = 1 for exactly one cycle; `rvalid0` returns 0x1234.
- Hold: `req1` held for 3 cycles while `req0` is continuous -> `gnt1` on the first cycle where `last` = 0. `addr1` remains stable and is presented on `mem_raddr` in that cycle.
- Reset mid-flight: LATENCY = 3, grant a read, assert `rst_n` = 0 one cycle later -> no `rvalid` is ever produced for that read; `last` = 1 after release.
